pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
// Owns the architectural PC, fetches instructions from instruction memory over a valid/ready request/response
// interface, and presents {Pc, Inst} to decode. It is the consumer side of the branch-resolution NewPc path:
// a taken branch or jump arrives as a redirect (RedirectValid/RedirectPc), and the unit discards any in-flight fetch.
// One outstanding imem request at a time; a one-entry registered output buffer toward decode.
// PARAMETERS
// DATA_W    32             datapath / address width
// RESET_PC  32'h0000_0000  PC fetched first after reset; must be 4-byte aligned
// PORTS
// Clk            in   1       clock, all state updates on rising edge
// Rst            in   1       synchronous, active-high reset
// RedirectValid  in   1       branch unit resolved a taken branch/jump this cycle
// RedirectPc     in   DATA_W  redirect target (NewPc)
// ImemReqValid   out  1       fetch request valid
// ImemReqAddr    out  DATA_W  fetch address; stable while ImemReqValid && !ImemReqReady
// ImemReqReady   in   1       imem accepts request
// ImemRespValid  in   1       fetch data valid (exactly one per accepted request, >=1 cycle after accept)
// ImemRespData   in   DATA_W  fetched instruction word
// InstValid      out  1       {InstPc, Inst} valid to decode
// InstPc         out  DATA_W  PC of presented instruction
// Inst           out  DATA_W  presented instruction
// InstReady      in   1       decode consumes instruction
// FetchFault     out  1       sticky: misaligned redirect received; fetch halted
// BEHAVIOUR
// - Reset (Rst=1 at an edge): State=IDLE, Pc=RESET_PC, ImemReqValid=0, ImemReqAddr=RESET_PC, InstValid=0,
//   InstPc=RESET_PC, Inst=0, Kill=0, FetchFault=0. Rst overrides every other input in any state, mid-transaction included.
//   A response still outstanding at reset is ignored because IDLE/REQ do not sample ImemResp*.
// - States: IDLE, REQ, WAIT, HOLD, FAULT. ImemReqValid=(State==REQ), ImemReqAddr=Pc, InstValid=(State==HOLD).
// - IDLE -> REQ unconditionally. The first request is visible one cycle after reset is released.
// - REQ: hold Pc until ImemReqReady. On handshake go to WAIT.
//   - A redirect in REQ without ImemReqReady replaces Pc next cycle, and the request is re-presented with the new address.
//     This is the single permitted address change.
//   - A redirect on the handshake cycle sets Kill=1 and loads Pc<=RedirectPc.
// - WAIT: on ImemRespValid with Kill=0 and no redirect, capture Inst<=ImemRespData, InstPc<=Pc, Pc<=Pc+4, go to HOLD.
//   - On ImemRespValid with Kill=1, or with a redirect the same cycle: discard the data, clear Kill, go to REQ.
//     Pc = latest redirect target.
//   - A redirect in WAIT without a response sets Kill=1 and Pc<=RedirectPc, then stays in WAIT.
// - HOLD: on InstReady go to REQ. Pc is RedirectPc if a redirect arrives the same cycle, else the already-incremented Pc.
//   - A redirect without InstReady drops the buffered instruction: InstValid=0 next cycle, Pc<=RedirectPc, go to REQ.
// - Redirect priority: a redirect always overrides the sequential Pc+4.
//   The instruction handed over on the InstReady cycle is still delivered.
// - Redirect with RedirectPc[1:0]!=0: ignore the target, set FetchFault=1, go to FAULT. Entered from any state.
//   - FAULT: ImemReqValid=0, InstValid=0, all inputs ignored; exit only by Rst.
// - ImemRespValid outside WAIT is ignored.
// - Pc+4 wraps modulo 2^DATA_W (32'hFFFF_FFFC -> 32'h0000_0000), with no flag.
// - Latency: response at edge N -> InstValid=1 from cycle N+1. Peak throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
// - Every output is registered or decoded from State only. No combinational path from inputs to outputs.
// TESTING
// - Reset/seq: Rst 2 cycles, imem zero-wait (ready=1, resp next cycle) -> addrs 0x0,0x4,0x8; InstPc matches; InstValid low during Rst.
// - Backpressure: InstReady=0 for 5 cycles in HOLD -> InstValid/Inst/InstPc stable, no new ImemReqValid; release -> next addr +4.
// - Kill in flight: redirect 0x100 in WAIT, response 0xDEADBEEF 2 cycles later -> discarded, next ImemReqAddr=0x100, InstPc=0x100.
// - Redirect+handoff: InstReady=1 and redirect 0x200 same cycle in HOLD -> current instruction consumed, next ImemReqAddr=0x200.
// - Wrap: RESET_PC=32'hFFFF_FFFC -> second ImemReqAddr=0x0.
// - Fault/reset: redirect 0x102 -> FetchFault=1, ImemReqValid=0 forever; Rst -> FetchFault=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus: redirect input, imem request/response, decode output.
// The fetch unit connects through master; the environment through slave.
interface pc_fetch_unit_if #(
    parameter int DATA_W = 32
);
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic [DATA_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_resp_valid;
    logic [DATA_W-1:0] imem_resp_data;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_pc;
    logic [DATA_W-1:0] inst;
    logic              inst_ready;
    logic              fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst_pc, inst, fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst_pc, inst, fetch_fault
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetcher: one outstanding imem request,
// one-entry output buffer to decode, redirect kills in-flight fetches.
module pc_fetch_unit #(
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_unit_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] pc, pc_nxt;
    logic [DATA_W-1:0] inst_pc_q, inst_pc_nxt;
    logic [DATA_W-1:0] inst_q, inst_nxt;
    logic              kill, kill_nxt;
    logic              redir_bad;
    logic              redir_ok;

    assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redir_ok  = bus.redirect_valid && !redir_bad;

    // All outputs come from registers or a state decode only.
    assign bus.imem_req_valid = (state == REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state == HOLD);
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst           = inst_q;
    assign bus.fetch_fault    = (state == FAULT);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            inst_pc_q <= RESET_PC;
            inst_q    <= '0;
            kill      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            inst_pc_q <= inst_pc_nxt;
            inst_q    <= inst_nxt;
            kill      <= kill_nxt;
        end
    end

    // Next-state logic; a redirect always wins over the sequential pc+4.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        inst_pc_nxt = inst_pc_q;
        inst_nxt    = inst_q;
        kill_nxt    = kill;
        unique case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redir_ok) pc_nxt = bus.redirect_pc;
            end
            REQ: begin
                if (bus.imem_req_ready) begin
                    state_nxt = WAIT;
                    if (redir_ok) begin
                        kill_nxt = 1'b1;
                        pc_nxt   = bus.redirect_pc;
                    end
                end else if (redir_ok) begin
                    pc_nxt = bus.redirect_pc;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (kill || redir_ok) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                        if (redir_ok) pc_nxt = bus.redirect_pc;
                    end else begin
                        inst_nxt    = bus.imem_resp_data;
                        inst_pc_nxt = pc;
                        pc_nxt      = pc + DATA_W'(4);
                        state_nxt   = HOLD;
                    end
                end else if (redir_ok) begin
                    kill_nxt = 1'b1;
                    pc_nxt   = bus.redirect_pc;
                end
            end
            HOLD: begin
                if (bus.inst_ready || redir_ok) begin
                    state_nxt = REQ;
                    if (redir_ok) pc_nxt = bus.redirect_pc;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A misaligned target halts fetch until reset.
        if (redir_bad) begin
            state_nxt   = FAULT;
            pc_nxt      = pc;
            inst_pc_nxt = inst_pc_q;
            inst_nxt    = inst_q;
            kill_nxt    = kill;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: imem responder, decode scoreboard,
// table of redirect runs and hand-written corner-case sequences.
module tb_pc_fetch_unit;
    localparam int W = 32;

    typedef struct {
        logic [31:0] target;
        int          n;
        int          lat;
        bit          rdy_rand;
        int          irdy;
        logic [31:0] exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic w_rst;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int          lat       = 1;
    bit          rdy_rand  = 1'b0;
    int          irdy_mode = 0;
    bit          sb_on     = 1'b0;
    bit          force_en  = 1'b0;
    logic [31:0] force_val = '0;
    logic [31:0] last_pc   = '0;
    logic [31:0] sb_pc[$];
    logic [31:0] acc_q[$];
    logic [31:0] wq[$];

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.DATA_W(W)) dif ();
    pc_fetch_unit_if #(.DATA_W(W)) wif ();

    pc_fetch_unit #(
        .DATA_W   (W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.master)
    );

    pc_fetch_unit #(
        .DATA_W   (W),
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk (clk),
        .rst (w_rst),
        .bus (wif.master)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // imem responder, decode-side ready driver and output monitor
    initial begin
        bit          acc;
        bit          pend;
        int          cnt;
        logic [31:0] acc_a;
        logic [31:0] paddr;
        logic [31:0] e;
        pend = 1'b0;
        cnt  = 0;
        paddr = '0;
        dif.imem_req_ready  = 1'b0;
        dif.imem_resp_valid = 1'b0;
        dif.imem_resp_data  = '0;
        dif.inst_ready      = 1'b0;
        forever begin
            @(negedge clk);
            acc   = dif.imem_req_valid && dif.imem_req_ready && !rst;
            acc_a = dif.imem_req_addr;
            if (acc) acc_q.push_back(acc_a);
            if (rst) pend = 1'b0;
            if (sb_on && dif.inst_valid && dif.inst_ready) begin
                if (sb_pc.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_inst: got pc %h expected none",
                             dif.inst_pc);
                end else begin
                    e = sb_pc.pop_front();
                    chk("sb_inst_pc", dif.inst_pc, e);
                    chk("sb_inst", dif.inst, data_of(e));
                    last_pc = dif.inst_pc;
                end
            end
            @(posedge clk);
            #1;
            dif.imem_resp_valid = 1'b0;
            if (acc) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = acc_a;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    dif.imem_resp_valid = 1'b1;
                    dif.imem_resp_data  = force_en ? force_val : data_of(paddr);
                    force_en = 1'b0;
                    pend     = 1'b0;
                end
            end
            dif.imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            dif.inst_ready = (irdy_mode == 2) ? 1'($urandom_range(0, 1))
                                              : (irdy_mode == 1);
        end
    end

    // second instance: zero-wait imem, RESET_PC at the top of memory
    initial begin
        bit          wacc;
        logic [31:0] wa;
        w_rst = 1'b1;
        wif.redirect_valid  = 1'b0;
        wif.redirect_pc     = '0;
        wif.imem_req_ready  = 1'b1;
        wif.inst_ready      = 1'b1;
        wif.imem_resp_valid = 1'b0;
        wif.imem_resp_data  = '0;
        repeat (2) @(posedge clk);
        #2 w_rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            wacc = wif.imem_req_valid;
            wa   = wif.imem_req_addr;
            if (wacc) wq.push_back(wa);
            @(posedge clk);
            #1;
            wif.imem_resp_valid = wacc;
            wif.imem_resp_data  = data_of(wa);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        dif.redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_valid", 32'(dif.inst_valid), 0);
        chk("rst_req_valid", 32'(dif.imem_req_valid), 0);
        chk("rst_req_addr", dif.imem_req_addr, 32'h0);
        chk("rst_inst_pc", dif.inst_pc, 32'h0);
        chk("rst_inst", dif.inst, 32'h0);
        chk("rst_fault", 32'(dif.fetch_fault), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        acc_q.delete();
    endtask

    task automatic wait_acc(input int n, input string name);
        repeat (200) begin
            if (acc_q.size() >= n) break;
            @(posedge clk);
        end
        chk(name, 32'(acc_q.size() >= n), 1);
    endtask

    task automatic wait_inst(input string name);
        repeat (100) begin
            @(negedge clk);
            if (dif.inst_valid) break;
        end
        chk(name, 32'(dif.inst_valid), 1);
    endtask

    task automatic wait_sb_empty();
        repeat (600) begin
            if (sb_pc.size() == 0) break;
            @(posedge clk);
        end
        chk("sb_drain", 32'(sb_pc.size()), 0);
        sb_pc.delete();
    endtask

    initial begin
        vec_t        vt[6];
        logic [31:0] snap_pc;
        logic [31:0] snap_inst;
        logic [31:0] a;
        bit          stable;
        bit          quiet;
        int          n0;

        vt[0] = '{32'h0000_1000, 4, 1, 1'b0, 1, 32'h0000_100C};
        vt[1] = '{32'h0000_2000, 5, 3, 1'b1, 1, 32'h0000_2010};
        vt[2] = '{32'h0000_3000, 4, 2, 1'b0, 2, 32'h0000_300C};
        vt[3] = '{32'hFFFF_FFF8, 4, 1, 1'b1, 2, 32'h0000_0004};
        vt[4] = '{32'h0000_0040, 6, 4, 1'b1, 2, 32'h0000_0054};
        vt[5] = '{32'h8000_0000, 3, 1, 1'b0, 1, 32'h8000_0008};

        rst = 1'b1;
        dif.redirect_valid = 1'b0;
        dif.redirect_pc    = '0;

        // reset and zero-wait sequential fetch
        lat = 1;
        rdy_rand = 1'b0;
        irdy_mode = 1;
        sb_on = 1'b1;
        do_reset();
        @(negedge clk);
        chk("first_req_idle", 32'(dif.imem_req_valid), 0);
        @(negedge clk);
        chk("first_req_valid", 32'(dif.imem_req_valid), 1);
        chk("first_req_addr", dif.imem_req_addr, 32'h0);
        sb_pc.push_back(32'h0);
        sb_pc.push_back(32'h4);
        sb_pc.push_back(32'h8);
        wait_sb_empty();
        irdy_mode = 0;
        sb_on = 1'b0;
        chk("seq_addr0", acc_q[0], 32'h0);
        chk("seq_addr1", acc_q[1], 32'h4);
        chk("seq_addr2", acc_q[2], 32'h8);

        // decode backpressure holds the buffer and blocks new requests
        irdy_mode = 0;
        do_reset();
        wait_inst("bp_wait");
        snap_pc   = dif.inst_pc;
        snap_inst = dif.inst;
        chk("bp_pc", snap_pc, 32'h0);
        chk("bp_inst", snap_inst, data_of(32'h0));
        n0 = acc_q.size();
        stable = 1'b1;
        quiet  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!dif.inst_valid || dif.inst !== snap_inst ||
                dif.inst_pc !== snap_pc) stable = 1'b0;
            if (dif.imem_req_valid) quiet = 1'b0;
        end
        chk("bp_stable", 32'(stable), 1);
        chk("bp_no_req", 32'(quiet), 1);
        irdy_mode = 1;
        wait_acc(n0 + 1, "bp_next_req");
        chk("bp_next_addr", acc_q[n0], snap_pc + 32'h4);
        irdy_mode = 0;

        // redirect while waiting kills the in-flight response
        lat = 3;
        irdy_mode = 1;
        do_reset();
        wait_acc(1, "kill_acc0");
        #2;
        force_val = 32'hDEAD_BEEF;
        force_en  = 1'b1;
        dif.redirect_valid = 1'b1;
        dif.redirect_pc    = 32'h0000_0100;
        @(posedge clk);
        #2;
        dif.redirect_valid = 1'b0;
        wait_acc(2, "kill_acc1");
        chk("kill_next_addr", acc_q[1], 32'h0000_0100);
        wait_inst("kill_wait");
        chk("kill_inst_pc", dif.inst_pc, 32'h0000_0100);
        chk("kill_inst", dif.inst, data_of(32'h0000_0100));
        irdy_mode = 0;
        lat = 1;

        // redirect on the handoff cycle still delivers the held instruction
        do_reset();
        wait_inst("ho_wait");
        irdy_mode = 1;
        @(posedge clk);
        #2;
        dif.redirect_valid = 1'b1;
        dif.redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        chk("ho_handshake", 32'(dif.inst_valid && dif.inst_ready), 1);
        chk("ho_inst_pc", dif.inst_pc, 32'h0);
        chk("ho_inst", dif.inst, data_of(32'h0));
        @(posedge clk);
        #2;
        dif.redirect_valid = 1'b0;
        irdy_mode = 0;
        wait_acc(2, "ho_acc1");
        chk("ho_next_addr", acc_q[1], 32'h0000_0200);

        // table of redirect runs checked through the scoreboard
        sb_on = 1'b1;
        foreach (vt[i]) begin
            irdy_mode = 0;
            lat       = vt[i].lat;
            rdy_rand  = vt[i].rdy_rand;
            @(posedge clk);
            #2;
            dif.redirect_valid = 1'b1;
            dif.redirect_pc    = vt[i].target;
            for (int k = 0; k < vt[i].n; k++) begin
                a = vt[i].target + 32'(4 * k);
                sb_pc.push_back(a);
            end
            @(posedge clk);
            #2;
            dif.redirect_valid = 1'b0;
            irdy_mode = vt[i].irdy;
            wait_sb_empty();
            irdy_mode = 0;
            chk("vec_last_pc", last_pc, vt[i].exp_last);
        end
        sb_on = 1'b0;
        rdy_rand = 1'b0;
        lat = 1;

        // misaligned redirect halts fetch until reset
        irdy_mode = 1;
        do_reset();
        repeat (4) @(posedge clk);
        #2;
        dif.redirect_valid = 1'b1;
        dif.redirect_pc    = 32'h0000_0102;
        @(posedge clk);
        #2;
        dif.redirect_valid = 1'b0;
        @(negedge clk);
        chk("fault_set", 32'(dif.fetch_fault), 1);
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dif.imem_req_valid || dif.inst_valid) quiet = 1'b0;
            if (c == 5) begin
                dif.redirect_valid = 1'b1;
                dif.redirect_pc    = 32'h0000_0300;
            end else begin
                dif.redirect_valid = 1'b0;
            end
        end
        chk("fault_quiet", 32'(quiet), 1);
        chk("fault_sticky", 32'(dif.fetch_fault), 1);
        do_reset();
        wait_acc(1, "fault_restart");
        chk("fault_restart_addr", acc_q[0], 32'h0);
        irdy_mode = 0;

        // wrap of pc+4 at the top of the address space
        chk("wrap_count", 32'(wq.size() >= 3), 1);
        chk("wrap_addr0", wq[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", wq[1], 32'h0000_0000);
        chk("wrap_addr2", wq[2], 32'h0000_0004);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
